// File: rtl/cpu_state_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_state_ctrl
//
// Multi-cycle sequencer for the MIPS CPU. Each instruction passes through the
// FETCH, EXEC1 and EXEC2 phases. A phase is stretched while the Avalon bus
// stalls (waitrequest) or while the multiply/divide unit is busy. The block
// issues exactly one pc_wen pulse per retired instruction. It also drives the
// bus strobes and the register-file write enable, detects halt (a fetch from
// address 0) and counts retired instructions.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, may be held for many cycles
//   waitrequest  Avalon stall for the current read or write
//   pc           current program counter
//   is_load      decoded from IR: the instruction reads data memory
//   is_store     decoded from IR: the instruction writes data memory
//   writes_reg   decoded from IR: the instruction writes a GPR
//   div_busy     multiply/divide unit still computing
//   active       CPU running (FETCH/EXEC1/EXEC2)
//   state        RESET=0, FETCH=1, EXEC1=2, EXEC2=3, HALTED=4
//   mem_read     Avalon read strobe
//   mem_write    Avalon write strobe
//   addr_sel     bus address select: 0 = PC, 1 = ALU result
//   ir_wen       instruction-register load
//   mdr_wen      load-data register capture
//   pc_wen       PC iterate enable, one pulse per instruction
//   reg_wen      register-file write enable
//   retired      count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module cpu_state_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                waitrequest,
  input  logic [31:0]         pc,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                writes_reg,
  input  logic                div_busy,
  output logic                active,
  output logic [2:0]          state,
  output logic                mem_read,
  output logic                mem_write,
  output logic                addr_sel,
  output logic                ir_wen,
  output logic                mdr_wen,
  output logic                pc_wen,
  output logic                reg_wen,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC1  = 3'd2,
    ST_EXEC2  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // Next-state and strobe decode. Strobes are combinational from the current
  // state and inputs so that read data is captured in the same cycle
  // waitrequest falls.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    active    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_wen    = 1'b0;
    mdr_wen   = 1'b0;
    pc_wen    = 1'b0;
    reg_wen   = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        active = 1'b1;
        // A fetch from address 0 is the halt condition: no bus access.
        if (pc == 32'd0) begin
          state_d = ST_HALTED;
        end else begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_wen  = 1'b1;
            state_d = ST_EXEC1;
          end
        end
      end

      ST_EXEC1: begin
        active = 1'b1;
        // Load wins when both decode bits are set, so read and write are
        // never driven together.
        if (is_load) begin
          mem_read = 1'b1;
          addr_sel = 1'b1;
          if (!waitrequest) begin
            mdr_wen = 1'b1;
            state_d = ST_EXEC2;
          end
        end else if (is_store) begin
          mem_write = 1'b1;
          addr_sel  = 1'b1;
          if (!waitrequest) begin
            state_d = ST_EXEC2;
          end
        end else begin
          state_d = ST_EXEC2;
        end
      end

      ST_EXEC2: begin
        active = 1'b1;
        if (!div_busy) begin
          pc_wen    = 1'b1;
          reg_wen   = writes_reg;
          retired_d = retired_q + 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Reset masks every strobe in the cycle it is asserted, whatever the state.
    if (reset) begin
      active    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = 1'b0;
      ir_wen    = 1'b0;
      mdr_wen   = 1'b0;
      pc_wen    = 1'b0;
      reg_wen   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_state_ctrl.sv
module tb_cpu_state_ctrl;

  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          waitrequest = 1'b0;
  logic [31:0]   pc = 32'd0;
  logic          is_load = 1'b0;
  logic          is_store = 1'b0;
  logic          writes_reg = 1'b0;
  logic          div_busy = 1'b0;
  logic          active;
  logic [2:0]    state;
  logic          mem_read;
  logic          mem_write;
  logic          addr_sel;
  logic          ir_wen;
  logic          mdr_wen;
  logic          pc_wen;
  logic          reg_wen;
  logic [RW-1:0] retired;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [RW-1:0] exp_ret = '0;
  logic [10:0]   got;

  cpu_state_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .pc(pc),
    .is_load(is_load), .is_store(is_store), .writes_reg(writes_reg),
    .div_busy(div_busy), .active(active), .state(state),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .ir_wen(ir_wen), .mdr_wen(mdr_wen), .pc_wen(pc_wen), .reg_wen(reg_wen),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // {state, active, mem_read, mem_write, addr_sel, ir_wen, mdr_wen, pc_wen, reg_wen}
  assign got = {state, active, mem_read, mem_write, addr_sel, ir_wen, mdr_wen, pc_wen, reg_wen};

  // One instruction, described by its stall counts. Expected outputs follow
  // from the position of each cycle inside the instruction:
  // nf+1 fetch cycles, 1 (ALU) or ne+1 (memory) EXEC1 cycles, nd+1 EXEC2 cycles.
  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1.
  task automatic run_instr(input int nf, input logic [1:0] kind, input int ne,
                           input int nd, input logic wr, input logic [31:0] pcv,
                           input string tag);
    int          n1;
    int          total;
    int          k;
    logic [10:0] exp;
    n1    = (kind == 2'd0) ? 1 : ne + 1;
    total = nf + 1 + n1 + nd + 1;
    for (int c = 0; c < total; c++) begin
      if (c <= nf) begin
        pc          = pcv;
        waitrequest = (c < nf);
        {is_load, is_store, writes_reg, div_busy} = 4'($urandom);
        exp = {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, (c == nf), 1'b0, 1'b0, 1'b0};
      end else if (c < nf + 1 + n1) begin
        k          = c - nf - 1;
        pc         = $urandom;
        is_load    = kind[0];
        is_store   = kind[1];
        writes_reg = 1'($urandom);
        div_busy   = 1'($urandom);
        if (kind == 2'd0) begin
          waitrequest = 1'($urandom);
          exp = {3'd2, 1'b1, 7'b0};
        end else begin
          waitrequest = (k < ne);
          exp = {3'd2, 1'b1, kind[0], ~kind[0], 1'b1, 1'b0,
                 (kind[0] && (k == ne)), 2'b00};
        end
      end else begin
        k           = c - nf - 1 - n1;
        pc          = $urandom;
        waitrequest = 1'($urandom);
        writes_reg  = wr;
        div_busy    = (k < nd);
        exp = {3'd3, 1'b1, 5'b0, (k == nd), ((k == nd) && wr)};
      end
      #4;
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d outputs: got %b required %b", tag, c, got, exp);
      end
      n_cmp++;
      if (retired !== exp_ret) begin
        n_err++;
        $display("FAIL %s cycle %0d retired: got %0d required %0d", tag, c, retired, exp_ret);
      end
      @(posedge clk); #1;
      if (c == total - 1) exp_ret = exp_ret + 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      pc = $urandom;
      {waitrequest, is_load, is_store, writes_reg, div_busy} = 5'($urandom);
      #4;
      n_cmp++;
      if (got !== 11'd0 || retired !== '0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %b/%0d required 0/0", i, got, retired);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    pc    = 32'hBFC0_0000;
    waitrequest = 1'b0;
    #4;
    n_cmp++;
    if (got !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state_cycle: got %b required %b", got, 11'd0);
    end
    @(posedge clk); #1;
    exp_ret = '0;
    run_instr(0, 2'd0, 0, 0, 1'b1, 32'hBFC0_0000, "reset_first_instr");
  endtask

  task automatic test_fetch_stall();
    run_instr(4, 2'd0, 0, 0, 1'b0, 32'hBFC0_0004, "fetch_stall");
  endtask

  task automatic test_load_store();
    run_instr(0, 2'd1, 2, 0, 1'b1, 32'hBFC0_0008, "load_wait2");
    run_instr(0, 2'd2, 2, 0, 1'b0, 32'hBFC0_000C, "store_wait2");
    run_instr(1, 2'd3, 1, 0, 1'b1, 32'hBFC0_0010, "load_store_both");
  endtask

  task automatic test_div_stall();
    run_instr(0, 2'd0, 0, 5, 1'b1, 32'hBFC0_0014, "div_stall");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_instr(int'($urandom_range(0, 3)), 2'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), $urandom | 32'h4, "random");
    end
  endtask

  task automatic test_halt();
    pc = 32'd0;
    waitrequest = 1'($urandom);
    #4;
    n_cmp++;
    if (got !== {3'd1, 1'b1, 7'b0}) begin
      n_err++;
      $display("FAIL halt_fetch: got %b required %b", got, {3'd1, 1'b1, 7'b0});
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      pc = $urandom;
      {waitrequest, is_load, is_store, writes_reg, div_busy} = 5'($urandom);
      #4;
      n_cmp++;
      if (got !== {3'd4, 8'b0} || retired !== exp_ret) begin
        n_err++;
        $display("FAIL halted cycle %0d: got %b/%0d required %b/%0d",
                 i, got, retired, {3'd4, 8'b0}, exp_ret);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #4;
    @(posedge clk); #1;
    #4;
    n_cmp++;
    if (got !== 11'd0 || retired !== '0) begin
      n_err++;
      $display("FAIL halt_reset: got %b/%0d required 0/0", got, retired);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ret = '0;
    pc = 32'hBFC0_0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    pc = 32'hBFC0_0020;
    waitrequest = 1'b0;
    is_load = 1'b1;
    is_store = 1'($urandom);
    #4;
    n_cmp++;
    if (got !== {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b0}) begin
      n_err++;
      $display("FAIL midload_fetch: got %b required %b", got,
               {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b0});
    end
    @(posedge clk); #1;
    waitrequest = 1'b1;
    writes_reg  = 1'b1;
    div_busy    = 1'b0;
    #4;
    n_cmp++;
    if (got !== {3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0}) begin
      n_err++;
      $display("FAIL midload_exec1: got %b required %b", got,
               {3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (got !== {3'd2, 8'b0}) begin
      n_err++;
      $display("FAIL midload_reset_same_cycle: got %b required %b", got, {3'd2, 8'b0});
    end
    @(posedge clk); #1;
    waitrequest = 1'b0;
    #4;
    n_cmp++;
    if (got !== 11'd0 || retired !== '0) begin
      n_err++;
      $display("FAIL midload_after_edge: got %b/%0d required 0/0", got, retired);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (got !== 11'd0) begin
      n_err++;
      $display("FAIL midload_reset_state: got %b required %b", got, 11'd0);
    end
    @(posedge clk); #1;
    exp_ret = '0;
    run_instr(0, 2'd1, 0, 1, 1'b1, 32'hBFC0_0000, "after_midload_reset");
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_load_store();
    test_div_stall();
    test_random();
    test_halt();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
